// File: rtl/ugt_threshold_monitor.sv
// Streaming over-threshold monitor: unsigned strict compare via subtract/carry, consecutive-run counter, registered alarm.
// Optional peak tracker enabled by defining UGT_THRESHOLD_MONITOR_PEAK_EN.
module ugt_threshold_monitor #(
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                   CLK,
    input  logic                   ASYNCRESET,
    input  logic                   LOAD,
    input  logic [WIDTH-1:0]       THRESH,
    input  logic [COUNT_WIDTH-1:0] HOLD,
    input  logic                   VALID,
    input  logic [WIDTH-1:0]       DATA,
    output logic                   O_GT,
    output logic [COUNT_WIDTH-1:0] O_COUNT,
`ifdef UGT_THRESHOLD_MONITOR_PEAK_EN
    output logic [WIDTH-1:0]       O_PEAK,
`endif
    output logic                   O_ALARM
);

    typedef enum logic [1:0] {
        BELOW  = 2'd0,
        ARMING = 2'd1,
        ALARM  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH-1:0]       r_thr;
    logic                   r_gt;
    logic [COUNT_WIDTH-1:0] r_count;
    logic [COUNT_WIDTH-1:0] w_count_nxt;
    logic [COUNT_WIDTH-1:0] w_count_sat;
    logic [COUNT_WIDTH:0]   w_count_inc;
    logic [COUNT_WIDTH-1:0] w_heff;
    logic [WIDTH:0]         w_sub;
    logic                   w_gt;

    // thr - DATA as thr + ~DATA + 1: carry-out set means thr >= DATA, so its inverse is DATA > thr.
    assign w_sub = {1'b0, r_thr} + {1'b0, ~DATA} + {{WIDTH{1'b0}}, 1'b1};
    assign w_gt  = ~w_sub[WIDTH];

    assign w_heff      = (HOLD == '0) ? COUNT_WIDTH'(1) : HOLD;
    assign w_count_inc = {1'b0, r_count} + {{COUNT_WIDTH{1'b0}}, 1'b1};
    assign w_count_sat = (&r_count) ? r_count : w_count_inc[COUNT_WIDTH-1:0];

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (VALID) begin
            unique case (r_state)
                BELOW: begin
                    if (w_gt) begin
                        w_count_nxt = COUNT_WIDTH'(1);
                        w_state_nxt = (w_heff == COUNT_WIDTH'(1)) ? ALARM : ARMING;
                    end else begin
                        w_count_nxt = '0;
                    end
                end
                ARMING: begin
                    if (w_gt) begin
                        w_count_nxt = w_count_sat;
                        // Wide compare so a saturated count still reaches any heff.
                        if (w_count_inc >= {1'b0, w_heff}) w_state_nxt = ALARM;
                    end else begin
                        w_count_nxt = '0;
                        w_state_nxt = BELOW;
                    end
                end
                ALARM: begin
                    if (w_gt) begin
                        w_count_nxt = w_count_sat;
                    end else begin
                        w_count_nxt = '0;
                        w_state_nxt = BELOW;
                    end
                end
                default: begin
                    w_count_nxt = '0;
                    w_state_nxt = BELOW;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (ASYNCRESET) begin
            r_thr   <= '0;
            r_gt    <= 1'b0;
            r_count <= '0;
            r_state <= BELOW;
        end else begin
            if (LOAD) r_thr <= THRESH;
            if (VALID) r_gt <= w_gt;
            r_count <= w_count_nxt;
            r_state <= w_state_nxt;
        end
    end

`ifdef UGT_THRESHOLD_MONITOR_PEAK_EN
    logic [WIDTH-1:0] r_peak;

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            r_peak <= '0;
        end else if (VALID) begin
            if (r_state != ALARM && w_state_nxt == ALARM) r_peak <= DATA;
            else if (r_state == ALARM && DATA > r_peak)   r_peak <= DATA;
        end
    end

    assign O_PEAK = r_peak;
`endif

    assign O_GT    = r_gt;
    assign O_COUNT = r_count;
    assign O_ALARM = (r_state == ALARM);

endmodule

// File: tb/tb_ugt_threshold_monitor.sv
// Scoreboard bench for ugt_threshold_monitor; covers the peak output when UGT_THRESHOLD_MONITOR_PEAK_EN is defined.
module tb_ugt_threshold_monitor;

    localparam int WIDTH       = 8;
    localparam int COUNT_WIDTH = 4;
    localparam int CNT_MAX     = (1 << COUNT_WIDTH) - 1;

    logic                   CLK = 1'b0;
    logic                   ASYNCRESET = 1'b0;
    logic                   LOAD = 1'b0;
    logic [WIDTH-1:0]       THRESH = '0;
    logic [COUNT_WIDTH-1:0] HOLD = '0;
    logic                   VALID = 1'b0;
    logic [WIDTH-1:0]       DATA = '0;
    logic                   O_GT;
    logic [COUNT_WIDTH-1:0] O_COUNT;
    logic                   O_ALARM;
`ifdef UGT_THRESHOLD_MONITOR_PEAK_EN
    logic [WIDTH-1:0]       O_PEAK;
`endif

    ugt_threshold_monitor #(.WIDTH(WIDTH), .COUNT_WIDTH(COUNT_WIDTH)) dut (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .LOAD       (LOAD),
        .THRESH     (THRESH),
        .HOLD       (HOLD),
        .VALID      (VALID),
        .DATA       (DATA),
        .O_GT       (O_GT),
        .O_COUNT    (O_COUNT),
`ifdef UGT_THRESHOLD_MONITOR_PEAK_EN
        .O_PEAK     (O_PEAK),
`endif
        .O_ALARM    (O_ALARM)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic                   gt;
        logic [COUNT_WIDTH-1:0] count;
        logic                   alarm;
        logic [WIDTH-1:0]       peak;
    } exp_t;

    exp_t q_exp[$];
    int   n_cmp = 0;
    int   n_mis = 0;

    // Reference model kept as plain integers: run length plus a sticky alarm flag.
    int   m_thr, m_count, m_peak;
    bit   m_gt, m_alarm;

    task automatic model_reset();
        m_thr = 0; m_count = 0; m_peak = 0; m_gt = 0; m_alarm = 0;
    endtask

    task automatic model_step(input bit ld, input int th, input int hd, input bit vl, input int dt);
        int  heff;
        bit  was_alarm;
        exp_t e;
        if (vl) begin
            heff      = (hd == 0) ? 1 : hd;
            was_alarm = m_alarm;
            m_gt      = (dt > m_thr);
            if (m_gt) begin
                m_count = (m_count < CNT_MAX) ? m_count + 1 : CNT_MAX;
                if (m_count >= heff) m_alarm = 1;
                if (m_alarm && !was_alarm)     m_peak = dt;
                else if (m_alarm && dt > m_peak) m_peak = dt;
            end else begin
                m_count = 0;
                m_alarm = 0;
            end
        end
        if (ld) m_thr = th;
        e.gt    = m_gt;
        e.count = m_count[COUNT_WIDTH-1:0];
        e.alarm = m_alarm;
        e.peak  = m_peak[WIDTH-1:0];
        q_exp.push_back(e);
    endtask

    task automatic scoreboard_pop_compare(input string tag);
        exp_t e;
        if (q_exp.size() == 0) begin
            n_cmp++; n_mis++;
            $display("FAIL %s: scoreboard empty when output expected", tag);
            return;
        end
        e = q_exp.pop_front();
        n_cmp++;
        if (O_GT !== e.gt) begin
            n_mis++;
            $display("FAIL %s gt: got %0b want %0b", tag, O_GT, e.gt);
        end
        n_cmp++;
        if (O_COUNT !== e.count) begin
            n_mis++;
            $display("FAIL %s count: got %0d want %0d", tag, O_COUNT, e.count);
        end
        n_cmp++;
        if (O_ALARM !== e.alarm) begin
            n_mis++;
            $display("FAIL %s alarm: got %0b want %0b", tag, O_ALARM, e.alarm);
        end
`ifdef UGT_THRESHOLD_MONITOR_PEAK_EN
        n_cmp++;
        if (O_PEAK !== e.peak) begin
            n_mis++;
            $display("FAIL %s peak: got %0d want %0d", tag, O_PEAK, e.peak);
        end
`endif
    endtask

    task automatic drive(input string tag, input bit ld, input int th, input int hd,
                         input bit vl, input int dt);
        @(negedge CLK);
        LOAD   = ld;
        THRESH = th[WIDTH-1:0];
        HOLD   = hd[COUNT_WIDTH-1:0];
        VALID  = vl;
        DATA   = dt[WIDTH-1:0];
        model_step(ld, th, hd, vl, dt);
        @(posedge CLK);
        #1;
        scoreboard_pop_compare(tag);
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        LOAD = 0; VALID = 0; ASYNCRESET = 1;
        @(negedge CLK);
        ASYNCRESET = 0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if (O_GT !== 1'b0 || O_COUNT !== '0 || O_ALARM !== 1'b0) begin
            n_mis++;
            $display("FAIL reset: got gt=%0b count=%0d alarm=%0b want 0/0/0", O_GT, O_COUNT, O_ALARM);
        end
    endtask

    task automatic test_basic_alarm();
        apply_reset();
        drive("t1_load", 1, 100, 3, 0, 0);
        drive("t1_d101", 0, 0, 3, 1, 101);
        drive("t1_d150", 0, 0, 3, 1, 150);
        n_cmp++;
        if (O_ALARM !== 1'b0) begin
            n_mis++;
            $display("FAIL t1_early_alarm: got %0b want 0", O_ALARM);
        end
        drive("t1_d200", 0, 0, 3, 1, 200);
        n_cmp++;
        if (O_ALARM !== 1'b1 || O_COUNT !== 4'd3) begin
            n_mis++;
            $display("FAIL t1_alarm: got alarm=%0b count=%0d want 1/3", O_ALARM, O_COUNT);
        end
    endtask

    task automatic test_equal_not_gt();
        apply_reset();
        drive("t2_load", 1, 100, 2, 0, 0);
        drive("t2_d101", 0, 0, 2, 1, 101);
        drive("t2_d100", 0, 0, 2, 1, 100);
        n_cmp++;
        if (O_GT !== 1'b0 || O_COUNT !== '0) begin
            n_mis++;
            $display("FAIL t2_equal: got gt=%0b count=%0d want 0/0", O_GT, O_COUNT);
        end
        drive("t2_d101b", 0, 0, 2, 1, 101);
        drive("t2_d99", 0, 0, 2, 1, 99);
    endtask

    task automatic test_hold_zero();
        apply_reset();
        drive("t3_load", 1, 5, 0, 0, 0);
        drive("t3_d6", 0, 0, 0, 1, 6);
        n_cmp++;
        if (O_ALARM !== 1'b1) begin
            n_mis++;
            $display("FAIL t3_alarm: got %0b want 1", O_ALARM);
        end
        drive("t3_d3", 0, 0, 0, 1, 3);
    endtask

    task automatic test_saturation();
        apply_reset();
        drive("t4_load", 1, 10, 2, 0, 0);
        for (int i = 0; i < 20; i++) begin
            drive($sformatf("t4_v%0d", i), 0, 0, 2, 1, 11 + $urandom_range(0, 200));
            if (i % 4 == 3) drive($sformatf("t4_idle%0d", i), 0, 0, 2, 0, $urandom_range(0, 255));
        end
        n_cmp++;
        if (O_COUNT !== 4'd15 || O_ALARM !== 1'b1) begin
            n_mis++;
            $display("FAIL t4_sat: got count=%0d alarm=%0b want 15/1", O_COUNT, O_ALARM);
        end
    endtask

    task automatic test_hold_change();
        apply_reset();
        drive("t7_load", 1, 20, 8, 0, 0);
        drive("t7_a", 0, 0, 8, 1, 30);
        drive("t7_b", 0, 0, 8, 1, 40);
        drive("t7_c", 0, 0, 8, 1, 50);
        drive("t7_h2", 0, 0, 2, 1, 60);
        drive("t7_h15", 0, 0, 15, 1, 70);
        drive("t7_drop", 0, 0, 15, 1, 5);
    endtask

    task automatic test_load_same_cycle();
        apply_reset();
        drive("t5_load50", 1, 50, 3, 0, 0);
        drive("t5_load200", 1, 200, 3, 1, 100);
        n_cmp++;
        if (O_GT !== 1'b1) begin
            n_mis++;
            $display("FAIL t5_old_thr: got %0b want 1", O_GT);
        end
        drive("t5_d100", 0, 0, 3, 1, 100);
        n_cmp++;
        if (O_GT !== 1'b0 || O_COUNT !== '0) begin
            n_mis++;
            $display("FAIL t5_new_thr: got gt=%0b count=%0d want 0/0", O_GT, O_COUNT);
        end
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        drive("t6_load", 1, 10, 4, 0, 0);
        drive("t6_a", 0, 0, 4, 1, 20);
        drive("t6_b", 0, 0, 4, 1, 30);
        @(negedge CLK);
        VALID = 0;
        #2;
        ASYNCRESET = 1;
        #1;
        n_cmp++;
        if (O_GT !== 1'b0 || O_COUNT !== '0 || O_ALARM !== 1'b0) begin
            n_mis++;
            $display("FAIL t6_async: got gt=%0b count=%0d alarm=%0b want 0/0/0", O_GT, O_COUNT, O_ALARM);
        end
        @(negedge CLK);
        ASYNCRESET = 0;
        model_reset();
        drive("t6_d1", 0, 0, 4, 1, 1);
        n_cmp++;
        if (O_GT !== 1'b1 || O_COUNT !== 4'd1 || O_ALARM !== 1'b0) begin
            n_mis++;
            $display("FAIL t6_after: got gt=%0b count=%0d alarm=%0b want 1/1/0", O_GT, O_COUNT, O_ALARM);
        end
    endtask

`ifdef UGT_THRESHOLD_MONITOR_PEAK_EN
    task automatic test_peak();
        apply_reset();
        drive("t8_load", 1, 50, 1, 0, 0);
        drive("t8_60", 0, 0, 1, 1, 60);
        drive("t8_90", 0, 0, 1, 1, 90);
        drive("t8_70", 0, 0, 1, 1, 70);
        n_cmp++;
        if (O_PEAK !== 8'd90) begin
            n_mis++;
            $display("FAIL t8_peak: got %0d want 90", O_PEAK);
        end
        drive("t8_leave", 0, 0, 1, 1, 10);
        drive("t8_reenter", 0, 0, 1, 1, 55);
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_basic_alarm();
        test_equal_not_gt();
        test_hold_zero();
        test_saturation();
        test_hold_change();
        test_load_same_cycle();
        test_reset_mid_run();
`ifdef UGT_THRESHOLD_MONITOR_PEAK_EN
        test_peak();
`endif
        n_cmp++;
        if (q_exp.size() != 0) begin
            n_mis++;
            $display("FAIL scoreboard_drain: got %0d left want 0", q_exp.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/ugt_threshold_monitor.md
Name: ugt_threshold_monitor

Overview:
- Sequential consumer of the unsigned greater-than comparator (the UGT datapath built from Sub-with-COUT plus an inverter).
- Compares a streaming unsigned sample against a programmable threshold, one sample per valid cycle.
- Counts consecutive samples strictly above the threshold.
- Raises a registered alarm once that run reaches a programmable hold length; used for over-level detection on ice40 designs.

Parameters:
- WIDTH, 8, bit width of sample and threshold; unsigned.
- COUNT_WIDTH, 4, width of the consecutive-run counter and of HOLD.

Ports:
- CLK  in  1  rising-edge clock.
- ASYNCRESET  in  1  asynchronous reset, active-high.
- LOAD  in  1  when high, capture THRESH into the threshold register.
- THRESH  in  WIDTH  new threshold value.
- HOLD  in  COUNT_WIDTH  consecutive above-threshold samples required for alarm; sampled every cycle.
- VALID  in  1  DATA is a valid sample this cycle.
- DATA  in  WIDTH  unsigned sample.
- O_GT  out  1  registered result of DATA > threshold for the most recent valid sample.
- O_COUNT  out  COUNT_WIDTH  current consecutive-run count.
- O_ALARM  out  1  alarm flag.

Behaviour:
- Reset, asynchronous on ASYNCRESET high:
  - threshold register = 0, state = BELOW.
  - O_GT = 0, O_COUNT = 0, O_ALARM = 0.
  - Reset is held while ASYNCRESET is high.
  - Reset mid-run discards the run; no alarm is produced until a fresh run completes.
- Compare:
  - gt = (DATA > thr), unsigned and strict; equality is not greater.
  - Implemented with the UGT-style subtract/carry path.
- Latency:
  - All outputs are registered.
  - The effect of a valid sample at edge k appears after edge k.
- LOAD:
  - Threshold updates at the edge.
  - When LOAD and VALID are high in the same cycle, the sample is compared against the old threshold; the new value applies from the next cycle.
  - LOAD does not change state, count, or alarm.
- VALID low: state, O_GT, O_COUNT and O_ALARM all hold.
- Effective hold: heff = (HOLD == 0) ? 1 : HOLD.
- State machine, transitions on VALID cycles only:
  - BELOW:
    - gt -> count = 1; go to ALARM if heff == 1, else ARMING.
    - !gt -> count = 0, stay BELOW.
  - ARMING:
    - gt -> count = count + 1; go to ALARM when (count + 1) >= heff.
    - !gt -> count = 0, go to BELOW.
  - ALARM:
    - gt -> count increments, saturating at 2^COUNT_WIDTH - 1; stay ALARM.
    - !gt -> count = 0, go to BELOW.
- Count saturation: the count never wraps; it saturates at all-ones in every state.
- HOLD change mid-run: the new heff is evaluated on the next valid sample.
  - If count already >= new heff, the next gt sample enters ALARM.
  - ALARM is never left because HOLD changes; only a !gt sample leaves it.
- O_ALARM = (state == ALARM).
- O_GT updates only on valid cycles.

Optional Feature:
- Macro: UGT_THRESHOLD_MONITOR_PEAK_EN.
- When defined:
  - Adds output O_PEAK (WIDTH bits).
  - O_PEAK holds the maximum DATA seen since the last entry into ALARM.
  - Reset value is 0.
  - On the BELOW/ARMING -> ALARM transition edge, it loads that sample.
  - While in ALARM, it updates when DATA > O_PEAK on valid cycles.
  - It holds its value after leaving ALARM.
- When undefined: O_PEAK does not exist and no peak register is built; all other behaviour is identical.

Test Plan:
1. Reset, LOAD THRESH = 100, HOLD = 3, then valid DATA 101, 150, 200 -> O_COUNT 1, 2, 3. O_ALARM rises after the third edge; O_GT = 1 throughout.
2. Threshold 100, HOLD = 2, DATA 101, 100 (equal), 101 -> O_GT 1, 0, 1; O_COUNT 1, 0, 1; O_ALARM never asserts.
3. HOLD = 0, threshold 5, single DATA 6 -> O_ALARM = 1 after one edge. Then DATA 3 -> O_ALARM = 0, O_COUNT = 0.
4. COUNT_WIDTH = 4, HOLD = 2, 20 consecutive DATA above threshold -> O_COUNT saturates at 15, O_ALARM stays 1. Interleaved VALID = 0 cycles leave all outputs unchanged.
5. Threshold 50; same cycle LOAD THRESH = 200 with VALID DATA 100 -> O_GT = 1 (old threshold). Next DATA 100 -> O_GT = 0, O_COUNT = 0.
6. In ARMING with count 2 (HOLD = 4), assert ASYNCRESET mid-cycle -> outputs 0 immediately, threshold 0. After release, DATA 1 -> O_GT = 1, O_COUNT = 1. With PEAK_EN: enter ALARM with 60, then 90, 70 -> O_PEAK 60, 90, 90.
